// File: rtl/fifo_pin_host.sv
// Purpose: host-side driver for the 6-bit FIFO tile's 8-pin interface; generates the tile clock, arbitrates write/read requests onto pins.
// Latency: one command per tile period (2*CLK_DIV clk); read response registered 2*CLK_DIV clk edges after the read handshake edge.
// Backpressure: wr_ready/rd_ready pulse only in the decision cycle (last high-phase cycle) for the granted, eligible channel; others must hold.
//
// Ports:
//   clk, reset           host clock, synchronous active-high reset
//   pin_out[7:0]         to tile: [0] tile clk, [1] mode, [7:2] write data or {peek, pop, reset_n}
//   pin_in[7:0]          from tile: [0] ready, [1] empty_n, [7:2] data
//   wr_valid/wr_data/wr_ready                write request channel
//   rd_valid/rd_pop/rd_peek/rd_ready         read request channel (rd_peek ignored on pop)
//   rsp_valid/rsp_data                       one-cycle read response strobe, data held until next response
//   init_done, tile_ready, tile_empty_n      status (tile flags sampled each decision cycle)
// CLK_DIV must be >= 1 and INIT_CYCLES >= 1.
module fifo_pin_host #(
    parameter int CLK_DIV     = 2,
    parameter int INIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] pin_out,
    input  logic [7:0] pin_in,
    input  logic       wr_valid,
    input  logic [5:0] wr_data,
    output logic       wr_ready,
    input  logic       rd_valid,
    input  logic       rd_pop,
    input  logic [1:0] rd_peek,
    output logic       rd_ready,
    output logic       rsp_valid,
    output logic [5:0] rsp_data,
    output logic       init_done,
    output logic       tile_ready,
    output logic       tile_empty_n
);

    localparam int PERIOD = 2 * CLK_DIV;
    localparam int PW     = $clog2(PERIOD);
    localparam int IW     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    localparam logic [PW-1:0] PH_LAST  = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PH_HIGH  = PW'(CLK_DIV);
    localparam logic [IW-1:0] INIT_END = IW'(INIT_CYCLES - 1);

    // pin_out[7:1] images: idle keeps the tile out of reset with no pop/peek
    localparam logic [6:0] PINS_RESET = 7'b000_0000;
    localparam logic [6:0] PINS_IDLE  = 7'b000_0010;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic [IW-1:0] init_cnt;
    logic          tclk;
    logic [6:0]    pins;
    logic          ptr_rd;    // 1: read wins the next dual-eligible decision
    logic          rd_pend;   // current tile period carries a READ command

    logic          decide;
    logic [PW-1:0] phase_nxt;
    logic          wr_elig;
    logic          rd_elig;
    logic          grant_wr;
    logic          grant_rd;

    assign decide    = (phase == PH_LAST);
    assign phase_nxt = decide ? '0 : phase + PW'(1);

    // Eligibility looks at the live tile flags: the decision cycle is the
    // sample point, the registered copies only become visible afterwards.
    assign wr_elig  = wr_valid & init_done & pin_in[0];
    assign rd_elig  = rd_valid & init_done & (~rd_pop | pin_in[1]);
    assign grant_rd = rd_elig & (~wr_elig | ptr_rd);
    assign grant_wr = wr_elig & (~rd_elig | ~ptr_rd);

    assign wr_ready = decide & grant_wr;
    assign rd_ready = decide & grant_rd;

    assign pin_out = {pins, tclk};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_INIT;
            phase        <= '0;
            init_cnt     <= '0;
            tclk         <= 1'b0;
            pins         <= PINS_RESET;
            ptr_rd       <= 1'b1;
            rd_pend      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            init_done    <= 1'b0;
            tile_ready   <= 1'b0;
            tile_empty_n <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            // Registered so the tile clock pin is glitch-free and aligned
            // with the command pins that change on the same edge.
            tclk      <= (phase_nxt >= PH_HIGH);
            rsp_valid <= 1'b0;

            // Command pins only move on the edge ending the decision cycle,
            // which is the high->low tile-clock transition.
            if (decide) begin
                tile_ready   <= pin_in[0];
                tile_empty_n <= pin_in[1];
                rd_pend      <= 1'b0;

                if (rd_pend) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= pin_in[7:2];
                end

                case (state)
                    ST_INIT: begin
                        if (init_cnt == INIT_END) begin
                            state     <= ST_RUN;
                            init_done <= 1'b1;
                            pins      <= PINS_IDLE;
                        end else begin
                            init_cnt <= init_cnt + IW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (wr_elig && rd_elig) begin
                            ptr_rd <= ~ptr_rd;
                        end
                        if (grant_wr) begin
                            pins <= {wr_data, 1'b1};
                        end else if (grant_rd) begin
                            pins    <= {2'b00, (rd_pop ? 2'b00 : rd_peek), rd_pop, 1'b1, 1'b0};
                            rd_pend <= 1'b1;
                        end else begin
                            pins <= PINS_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_pin_host.sv
// Purpose: directed self-checking bench for fifo_pin_host with a read-response scoreboard.
// Latency: responses expected 2*CLK_DIV edges after the read handshake edge (one extra negedge sample).
// Backpressure: requests held until the DUT's ready pulse; blocked cases checked for ready staying low.
module tb_fifo_pin_host;

    localparam int CLK_DIV     = 2;
    localparam int INIT_CYCLES = 4;
    localparam int PERIOD      = 2 * CLK_DIV;
    localparam logic [6:0] PINS_IDLE = 7'b000_0010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pin_out;
    logic [7:0] pin_in = 8'h00;
    logic       wr_valid = 1'b0;
    logic [5:0] wr_data = 6'h00;
    logic       wr_ready;
    logic       rd_valid = 1'b0;
    logic       rd_pop = 1'b0;
    logic [1:0] rd_peek = 2'b00;
    logic       rd_ready;
    logic       rsp_valid;
    logic [5:0] rsp_data;
    logic       init_done;
    logic       tile_ready;
    logic       tile_empty_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_phase = 0;

    typedef struct {
        logic [5:0] data;
        int         c;
    } exp_t;
    exp_t sb[$];

    fifo_pin_host #(
        .CLK_DIV     (CLK_DIV),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pin_out      (pin_out),
        .pin_in       (pin_in),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_pop       (rd_pop),
        .rd_peek      (rd_peek),
        .rd_ready     (rd_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .init_done    (init_done),
        .tile_ready   (tile_ready),
        .tile_empty_n (tile_empty_n)
    );

    always #5 clk = ~clk;

    // Reference phase of the tile clock, restarted by reset.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        m_phase <= reset ? 0 : ((m_phase == PERIOD - 1) ? 0 : m_phase + 1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Continuous checks: tile clock shape, ready only in the decision cycle,
    // and every response matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        chk("tile_clk", pin_out[0], (m_phase >= CLK_DIV));
        if (m_phase != PERIOD - 1) begin
            chk("wr_ready_offdecision", wr_ready, 0);
            chk("rd_ready_offdecision", rd_ready, 0);
        end
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_latency", cyc - e.c, PERIOD + 1);
            end
        end
    end

    task automatic do_write(input logic [5:0] d);
        bit got = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            #1;
            if (wr_ready === 1'b1) begin
                got = 1;
                break;
            end
            tick();
        end
        chk("wr_grant_seen", got, 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic pop, input logic [1:0] peek, input logic [5:0] word, input bit expect_rsp);
        bit got = 0;
        rd_valid = 1'b1;
        rd_pop   = pop;
        rd_peek  = peek;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            #1;
            if (rd_ready === 1'b1) begin
                got = 1;
                if (expect_rsp) sb.push_back('{data: word, c: cyc});
                break;
            end
            tick();
        end
        chk("rd_grant_seen", got, 1);
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3 * PERIOD; i++) begin
            #1;
            if (sb.size() == 0) break;
            tick();
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic check_init_sequence();
        for (int i = 0; i < PERIOD * INIT_CYCLES; i++) begin
            chk("init_pin2_low", pin_out[2], 0);
            chk("init_done_low", init_done, 0);
            chk("init_rsp_quiet", rsp_valid, 0);
            tick();
        end
        chk("init_done", init_done, 1);
        chk("idle_pins", pin_out[7:1], PINS_IDLE);
    endtask

    initial begin
        bit exp_rd;

        // Reset values
        repeat (3) tick();
        chk("rst_pin_out", pin_out, 8'h00);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_tile_ready", tile_ready, 0);
        chk("rst_tile_empty_n", tile_empty_n, 0);

        // Tile held in reset for INIT_CYCLES periods, then idle
        reset = 1'b0;
        check_init_sequence();

        // Write 6'h2A with tile ready
        pin_in = 8'b0000_0001;
        do_write(6'h2A);
        chk("wr_pins_low", pin_out, 8'hAA);
        tick(); tick();
        chk("wr_pins_high", pin_out, 8'hAB);
        chk("tile_ready_high", tile_ready, 1);
        tick(); tick();
        chk("idle_after_write", pin_out, 8'h04);

        // Write blocked while tile not ready, issues once ready returns
        pin_in   = 8'b0000_0000;
        wr_valid = 1'b1;
        wr_data  = 6'h11;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            #1;
            chk("wr_blocked", wr_ready, 0);
            chk("blocked_pins", pin_out[7:1], PINS_IDLE);
            tick();
        end
        chk("tile_ready_low", tile_ready, 0);
        pin_in = 8'b0000_0001;
        do_write(6'h11);
        chk("wr2_pins", pin_out, 8'h46);

        // Pop with data available, tile returns 6'h15
        pin_in = {6'h15, 2'b11};
        do_read(1'b1, 2'd2, 6'h15, 1);
        chk("pop_pins", pin_out, 8'h0C);
        chk("tile_empty_n_high", tile_empty_n, 1);
        wait_drain();

        // Pop blocked while empty; peek index 3 still accepted
        pin_in   = {6'h3C, 2'b01};
        rd_valid = 1'b1;
        rd_pop   = 1'b1;
        rd_peek  = 2'd0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            #1;
            chk("pop_blocked", rd_ready, 0);
            tick();
        end
        rd_valid = 1'b0;
        chk("tile_empty_n_low", tile_empty_n, 0);
        do_read(1'b0, 2'd3, 6'h3C, 1);
        chk("peek_pins", pin_out, 8'h34);
        wait_drain();

        // Both channels eligible: alternate starting with read
        pin_in   = {6'h07, 2'b11};
        wr_valid = 1'b1;
        wr_data  = 6'h33;
        rd_valid = 1'b1;
        rd_pop   = 1'b1;
        rd_peek  = 2'd0;
        exp_rd   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2 * PERIOD; i++) begin
                #1;
                if (wr_ready === 1'b1 || rd_ready === 1'b1) break;
                tick();
            end
            chk("dual_grant", {wr_ready, rd_ready}, exp_rd ? 2'b01 : 2'b10);
            if (rd_ready === 1'b1) sb.push_back('{data: 6'h07, c: cyc});
            exp_rd = !exp_rd;
            tick();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        wait_drain();

        // Reset during a READ period drops the response and restarts INIT
        pin_in = {6'h2E, 2'b11};
        do_read(1'b1, 2'd0, 6'h2E, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_pin_out", pin_out, 8'h00);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        chk("midrst_init_done", init_done, 0);
        reset = 1'b0;
        check_init_sequence();

        chk("sb_empty_end", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_pin_host.md
Name: fifo_pin_host

Overview:
- Host-side controller for the 6-bit FIFO tile's 8-pin interface.
- Generates the tile clock and drives the mode, write, pop, peek and reset pins.
- Samples the tile's ready, empty_n and data pins.
- Exposes two independent valid/ready request channels (write, read) plus a read-response strobe to system logic running on the single host clock.

Parameters:
- CLK_DIV, 2: host clk cycles per tile-clock half-period; must be ≥1.
- INIT_CYCLES, 4: tile-clock periods the tile is held in reset after host reset.

Ports:
- clk  in  1  host clock
- reset  in  1  synchronous, active-high reset
- pin_out  out  8  to tile inputs:
  - [0] tile clk
  - [1] mode
  - [2] data[0] in write mode / reset_n in read mode
  - [3] data[1] in write mode / pop in read mode
  - [7:4] data[5:2] in write mode / peek in read mode
- pin_in  in  8  from tile outputs: [0] ready, [1] empty_n, [7:2] data
- wr_valid  in  1  write request
- wr_data  in  6  word to push
- wr_ready  out  1  write accepted this cycle when wr_valid=1
- rd_valid  in  1  read request
- rd_pop  in  1  1 = pop head, 0 = peek only
- rd_peek  in  2  entry index (0 = head); forced to 0 when rd_pop=1
- rd_ready  out  1  read accepted this cycle when rd_valid=1
- rsp_valid  out  1  one-cycle strobe, rsp_data valid
- rsp_data  out  6  word returned by the tile
- init_done  out  1  tile out of reset, channels live
- tile_ready  out  1  last sampled pin_in[0]
- tile_empty_n  out  1  last sampled pin_in[1]

Behaviour:
- Tile clock period = 2*CLK_DIV host cycles.
  - Low phase: pin_out[0]=0 for CLK_DIV cycles.
  - High phase: pin_out[0]=1 for CLK_DIV cycles.
  - One phase counter counts 0..2*CLK_DIV-1.
- pin_out[7:1] changes only at the high→low transition, so it is stable across each tile rising edge.
- Decision cycle = last host cycle of the high phase. In that cycle:
  - tile_ready/tile_empty_n load from pin_in[1:0].
  - Arbitration runs.
  - wr_ready/rd_ready may assert; they are 0 in every other cycle.
- Reset values: pin_out=8'h00 (mode=0, reset_n=0, i.e. tile in reset), wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0, init_done=0, tile_ready=0, tile_empty_n=0, phase=0, arbitration pointer=read.
- States:
  - INIT: pins = mode 0, pin[2]=0. Stays for INIT_CYCLES tile periods, then → RUN at a high→low transition; init_done=1 from that transition.
  - RUN: each tile period drives one command: IDLE, WRITE or READ.
- Default (IDLE) pins: mode=0, pin[2]=1, pop=0, peek=0. The tile clock keeps running so tile-internal transfers progress.
- Write eligible: wr_valid & init_done & pin_in[0]=1 sampled in the decision cycle.
- Read eligible: rd_valid & init_done & (rd_pop=0 | pin_in[1]=1). Peek-only reads are allowed while empty; data is unspecified.
- Arbitration:
  - Only one eligible → grant it.
  - Both eligible → grant per pointer; pointer flips after every dual-eligible grant.
  - Granted channel's ready=1 for exactly that decision cycle; the handshake completes there.
- WRITE period pins: mode=1, pin[7:2]=wr_data captured at the grant.
- READ period pins: mode=0, pin[2]=1, pin[3]=rd_pop, pin[7:4]={2'b00, rd_peek}.
- Read response: captured at the decision cycle ending the READ period, from pin_in[7:2].
  - rsp_data holds that value; rsp_valid=1 for that one host cycle.
  - Latency from rd handshake = 2*CLK_DIV host cycles.
  - rsp_data holds until the next response.
- No response path for writes; the write is complete once the READ/WRITE period ends.
- Ungranted requests: ready stays 0; requester keeps valid and data stable until granted.
- Reset mid-operation: everything returns to reset values and INIT restarts; any pending response is dropped (no rsp_valid).
- CLK_DIV=1: low and high phases are one cycle each; the decision cycle is the single high cycle.

Test Plan:
- Reset then idle, CLK_DIV=2 → pin_out[0] toggles every 2 cycles; pin_out[2]=0 for 4 tile periods, then init_done=1, pin_out[2]=1, pin_out[1]=0.
- Write 6'h2A with pin_in[0]=1 → wr_ready pulses in the decision cycle; next period pin_out=8'b1010_1010 with bit0 following tile clk (bit1=1).
- Write with pin_in[0]=0 → wr_ready stays 0 and pins stay IDLE until ready=1, then the write issues in the following period.
- Pop with empty_n=1, tile returning 6'h15 → pin_out[3]=1, peek=0; rsp_valid one cycle later by 4 host cycles, rsp_data=6'h15.
- Pop with empty_n=0 → rd_ready=0. Peek rd_peek=3, rd_pop=0 while empty → accepted, pin_out[7:4]=4'b0011, pin_out[3]=0.
- wr and rd both eligible for 4 periods → grants read, write, read, write; assert reset mid-READ → no rsp_valid, pin_out=8'h00 next cycle.
